// File: rtl/slice_add_pkg.sv
// Shared constants and state encoding for the slice-serial adder.
package slice_add_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/r4_adder.sv
// Gate-level 4-bit ripple-carry adder slice.
module r4_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;
    logic [3:0] p;
    logic [3:0] g;

    assign c[0] = cin;
    assign p    = a ^ b;
    assign g    = a & b;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]     = p[i] ^ c[i];
        assign c[i+1]   = g[i] | (p[i] & c[i]);
    end

    assign cout = c[4];

endmodule

// File: rtl/slice_add_seq.sv
// Multi-cycle WIDTH-bit adder using one 4-bit slice per clock, LSB first.
// Define SLICE_ADD_SEQ_SUB_EN to add a 'sub' input selecting A-B.
module slice_add_seq
    import slice_add_pkg::*;
#(
    parameter int unsigned NSLICES = 4,
    localparam int unsigned WIDTH  = SLICE_W * NSLICES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SLICE_ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned IDXW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICES - 1);

    state_t             state;
    logic [IDXW-1:0]    idx;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;
    logic [WIDTH-1:0]   b_in;
    logic               c_in;

`ifdef SLICE_ADD_SEQ_SUB_EN
    // Subtract as A + ~B + 1; cout then reads as "no borrow".
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    r4_adder u_slice (
        .a    (a_r[SLICE_W*idx +: SLICE_W]),
        .b    (b_r[SLICE_W*idx +: SLICE_W]),
        .cin  (carry_r),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b_in;
                        carry_r  <= c_in;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[SLICE_W*idx +: SLICE_W] <= slice_s;
                    carry_r                     <= slice_c;
                    idx                         <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout      <= slice_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
